arb4_rr_ctrl: RTL and testbench

- Four-requester arbiter that shares one downstream resource (e.g. an encoder or bus slot) between requesters 0..3.
- Picks one winner per transaction by round-robin, or by fixed priority (3 highest).
- Holds the grant until the winner signals done, then returns to idle.
- Drives a one-hot grant plus a 2-bit encoded grant index for the shared datapath select.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/rr_pick4.sv | 33 +++
 rtl/arb4_rr_ctrl.sv | 130 +++++++++++++
 tb/tb_arb4_rr_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester arbiter: FSM state encoding,
// requester count, index width and a one-hot helper.
package arb_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } state_e;

  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational winner selection: round-robin search starting at i_ptr, or
// fixed priority (highest index wins) when i_mode is high.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_mode,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_idx  = '0;
    w_cand = '0;
    o_any  = |i_req;
    if (i_mode) begin
      for (int k = 0; k < NREQ; k++) begin
        if (i_req[k]) o_idx = IDX_W'(k);
      end
    end else begin
      // Walk offsets from far to near so the closest requester after i_ptr is assigned last.
      for (int k = NREQ - 1; k >= 0; k--) begin
        w_cand = i_ptr + IDX_W'(k);
        if (i_req[w_cand]) o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/arb4_rr_ctrl.sv
// Four-requester arbiter FSM (IDLE -> GRANT -> RELEASE) with registered grant outputs.
// Define ARB_TIMEOUT_EN to add the MAX_HOLD forced-release counter and timeout port.
module arb4_rr_ctrl
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  input  logic             pri_mode,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  state_e           r_state;
  logic [NREQ-1:0]  r_gnt;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [IDX_W-1:0] r_ptr;
  logic             r_gnt_vld;
  logic             r_busy;
  logic             r_mode;

  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic             w_release_norm;
  logic             w_release;

  rr_pick4 u_pick (
    .i_req  (req),
    .i_ptr  (r_ptr),
    .i_mode (pri_mode),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  assign w_release_norm = done | ~req[r_gnt_idx];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic             w_force;

  // Counter holds cycles already spent in GRANT, so the grant is visible for MAX_HOLD cycles.
  assign w_force   = ~w_release_norm & ((r_cnt + CNT_W'(1)) == CNT_W'(MAX_HOLD));
  assign w_release = w_release_norm | w_force;
  assign timeout   = r_timeout;
`else
  assign w_release = w_release_norm;
`endif

  assign gnt     = r_gnt;
  assign gnt_idx = r_gnt_idx;
  assign gnt_vld = r_gnt_vld;
  assign busy    = r_busy;

  // NOTE: sequential state uses <= so all flops update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_ptr     <= '0;
      r_gnt_vld <= 1'b0;
      r_busy    <= 1'b0;
      r_mode    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_state   <= GRANT;
            r_gnt     <= idx_to_onehot(w_pick_idx);
            r_gnt_idx <= w_pick_idx;
            r_gnt_vld <= 1'b1;
            r_busy    <= 1'b1;
            r_mode    <= pri_mode;
`ifdef ARB_TIMEOUT_EN
            r_cnt     <= '0;
`endif
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state   <= RELEASE;
            r_gnt     <= '0;
            r_gnt_vld <= 1'b0;
            if (!r_mode) r_ptr <= r_gnt_idx + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
            r_timeout <= w_force;
`endif
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        RELEASE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_gnt     <= '0;
          r_gnt_vld <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Self-checking bench for arb4_rr_ctrl: directed vector table, hand-written reset and
// timeout sequences, then randomized traffic against a behavioural model.
module tb_arb4_rr_ctrl;

  localparam int TB_MAX_HOLD = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic       pri_mode;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       busy;
`ifdef ARB_TIMEOUT_EN
  logic       timeout;
`endif

  int n_checks = 0;
  int n_err    = 0;

  arb4_rr_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .pri_mode (pri_mode),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_vld  (gnt_vld),
    .busy     (busy)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout  (timeout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic       pri;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: who owns the resource, whether a dead cycle is pending, pointer.
  int m_owner;
  int m_last;
  int m_ptr;
  bit m_gap;
  bit m_fixed;
  bit m_to;
`ifdef ARB_TIMEOUT_EN
  int m_held;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic d, input logic p,
                     input logic [3:0] g, input logic [1:0] i, input logic v, input logic b);
    vec_t e;
    e.req = r; e.done = d; e.pri = p; e.gnt = g; e.idx = i; e.vld = v; e.busy = b;
    vecs.push_back(e);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_ptr   = 0;
    m_gap   = 1'b0;
    m_fixed = 1'b0;
    m_to    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    m_held  = 0;
`endif
  endtask

  task automatic model_step();
    bit rel;
    bit frc;
    int c;
    m_to = 1'b0;
    frc  = 1'b0;
    if (m_owner >= 0) begin
      rel = done || !req[m_owner];
`ifdef ARB_TIMEOUT_EN
      frc = !rel && (m_held == TB_MAX_HOLD);
      m_held++;
`endif
      if (rel || frc) begin
        m_to = frc;
        if (!m_fixed) m_ptr = (m_last + 1) % 4;
        m_owner = -1;
        m_gap   = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (req != 4'b0000) begin
      m_fixed = pri_mode;
      if (pri_mode) begin
        for (int i = 0; i < 4; i++) begin
          if (req[i]) m_owner = i;
        end
      end else begin
        for (int off = 0; off < 4; off++) begin
          c = (m_ptr + off) % 4;
          if (req[c] && m_owner < 0) m_owner = c;
        end
      end
      m_last = m_owner;
`ifdef ARB_TIMEOUT_EN
      m_held = 1;
`endif
    end
  endtask

  // Advance one clock: inputs are stable across the rising edge, outputs sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    check({tag, " gnt"},  32'(gnt), 32'(eg));
    check({tag, " idx"},  32'(gnt_idx), 32'(m_last));
    check({tag, " vld"},  32'(gnt_vld), 32'(m_owner >= 0));
    check({tag, " busy"}, 32'(busy), 32'((m_owner >= 0) || m_gap));
`ifdef ARB_TIMEOUT_EN
    check({tag, " timeout"}, 32'(timeout), 32'(m_to));
`endif
  endtask

  initial begin
    // Round-robin fairness from ptr 0
    add(4'b1111, 0, 0, 4'b0001, 2'd0, 1, 1);
    add(4'b1111, 1, 0, 4'b0000, 2'd0, 0, 1);
    add(4'b1111, 0, 0, 4'b0000, 2'd0, 0, 0);
    add(4'b1111, 0, 0, 4'b0010, 2'd1, 1, 1);
    add(4'b1111, 1, 0, 4'b0000, 2'd1, 0, 1);
    add(4'b1111, 0, 0, 4'b0000, 2'd1, 0, 0);
    add(4'b1111, 0, 0, 4'b0100, 2'd2, 1, 1);
    add(4'b1111, 1, 0, 4'b0000, 2'd2, 0, 1);
    add(4'b1111, 0, 0, 4'b0000, 2'd2, 0, 0);
    add(4'b1111, 0, 0, 4'b1000, 2'd3, 1, 1);
    add(4'b1111, 1, 0, 4'b0000, 2'd3, 0, 1);
    add(4'b1111, 0, 0, 4'b0000, 2'd3, 0, 0);
    add(4'b1111, 0, 0, 4'b0001, 2'd0, 1, 1);
    add(4'b1111, 1, 0, 4'b0000, 2'd0, 0, 1);
    add(4'b0000, 0, 0, 4'b0000, 2'd0, 0, 0);
    // Fixed priority; pri_mode change inside GRANT has no effect
    add(4'b0110, 0, 1, 4'b0100, 2'd2, 1, 1);
    add(4'b0110, 1, 0, 4'b0000, 2'd2, 0, 1);
    add(4'b0011, 0, 1, 4'b0000, 2'd2, 0, 0);
    add(4'b0011, 0, 1, 4'b0010, 2'd1, 1, 1);
    add(4'b0011, 1, 1, 4'b0000, 2'd1, 0, 1);
    add(4'b0000, 0, 0, 4'b0000, 2'd1, 0, 0);
    // Withdrawal then skip past requester 0 (ptr = 2)
    add(4'b0010, 0, 0, 4'b0010, 2'd1, 1, 1);
    add(4'b1111, 0, 0, 4'b0010, 2'd1, 1, 1);
    add(4'b1101, 0, 0, 4'b0000, 2'd1, 0, 1);
    add(4'b1001, 0, 0, 4'b0000, 2'd1, 0, 0);
    add(4'b1001, 0, 0, 4'b1000, 2'd3, 1, 1);
    // Simultaneous done + withdrawal, then done ignored while not granted; wrap to ptr 0
    add(4'b0000, 1, 0, 4'b0000, 2'd3, 0, 1);
    add(4'b0000, 1, 0, 4'b0000, 2'd3, 0, 0);
    add(4'b0000, 1, 0, 4'b0000, 2'd3, 0, 0);
    add(4'b0011, 0, 0, 4'b0001, 2'd0, 1, 1);
    add(4'b0011, 0, 0, 4'b0001, 2'd0, 1, 1);

    // Reset held with requests pending
    rst_n = 1'b0; req = 4'b1111; done = 1'b0; pri_mode = 1'b0;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    check("rst gnt", 32'(gnt), 32'h0);
    check("rst idx", 32'(gnt_idx), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst vld", 32'(gnt_vld), 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      req = vecs[i].req; done = vecs[i].done; pri_mode = vecs[i].pri;
      tick();
      check($sformatf("row%0d gnt", i),  32'(gnt),     32'(vecs[i].gnt));
      check($sformatf("row%0d idx", i),  32'(gnt_idx), 32'(vecs[i].idx));
      check($sformatf("row%0d vld", i),  32'(gnt_vld), 32'(vecs[i].vld));
      check($sformatf("row%0d busy", i), 32'(busy),    32'(vecs[i].busy));
    end

    // Move ptr to 1, grant requester 2, then reset asynchronously between edges
    req = 4'b0011; done = 1'b1;
    tick();
    check("pre gnt", 32'(gnt), 32'h0);
    req = 4'b0100; done = 1'b0;
    tick();
    tick();
    check("pre grant2", 32'(gnt), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("async gnt", 32'(gnt), 32'h0);
    check("async vld", 32'(gnt_vld), 32'h0);
    check("async busy", 32'(busy), 32'h0);
    check("async idx", 32'(gnt_idx), 32'h0);
    req = 4'b1111;
    @(negedge clk);
    tick();
    check("async held gnt", 32'(gnt), 32'h0);
    rst_n = 1'b1;
    tick();
    check("restart gnt", 32'(gnt), 32'h1);
    check("restart idx", 32'(gnt_idx), 32'h0);

`ifdef ARB_TIMEOUT_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; req = 4'b0001; done = 1'b0; pri_mode = 1'b0;
    tick();
    check("to grant", 32'(gnt), 32'h1);
    for (int k = 1; k < TB_MAX_HOLD; k++) begin
      tick();
      check($sformatf("to hold%0d", k), 32'(gnt), 32'h1);
      check($sformatf("to quiet%0d", k), 32'(timeout), 32'h0);
    end
    tick();
    check("to release gnt", 32'(gnt), 32'h0);
    check("to pulse", 32'(timeout), 32'h1);
    check("to busy", 32'(busy), 32'h1);
    tick();
    check("to pulse end", 32'(timeout), 32'h0);
    tick();
    check("to regrant", 32'(gnt), 32'h1);
`endif

    // Randomized traffic against the model
    rst_n = 1'b0; req = 4'b0000; done = 1'b0; pri_mode = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0) pri_mode = ~pri_mode;
      tick();
      check_model($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
